// File: rtl/wb_port_arbiter_if.sv
// Writeback port arbiter bus interface.
// Groups the three writeback requesters, the write-port stall and the
// registered register-file write port into one bundle.
//   req_i        per-source write request, bit k = source k
//   addrK_i      destination register of source K
//   dataK_i      write data of source K
//   stall_i      write port unavailable this cycle
//   ack_o        one-hot combinational grant
//   wb_valid_o   write-port enable (registered)
//   wb_sel_o     select code of the source on the port (registered)
//   wb_addr_o    write-port address (registered)
//   wb_data_o    write-port data (registered)
// Modports: master = requesters / register-file side, slave = arbiter.
interface wb_port_arbiter_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 4
) ();
    logic [2:0]        req_i;
    logic [ADDR_W-1:0] addr0_i;
    logic [ADDR_W-1:0] addr1_i;
    logic [ADDR_W-1:0] addr2_i;
    logic [WIDTH-1:0]  data0_i;
    logic [WIDTH-1:0]  data1_i;
    logic [WIDTH-1:0]  data2_i;
    logic              stall_i;
    logic [2:0]        ack_o;
    logic              wb_valid_o;
    logic [1:0]        wb_sel_o;
    logic [ADDR_W-1:0] wb_addr_o;
    logic [WIDTH-1:0]  wb_data_o;

    modport master (
        output req_i, addr0_i, addr1_i, addr2_i, data0_i, data1_i, data2_i, stall_i,
        input  ack_o, wb_valid_o, wb_sel_o, wb_addr_o, wb_data_o
    );

    modport slave (
        input  req_i, addr0_i, addr1_i, addr2_i, data0_i, data1_i, data2_i, stall_i,
        output ack_o, wb_valid_o, wb_sel_o, wb_addr_o, wb_data_o
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter.
// Shares the single register-file write port between three writeback sources
// (0 = ALU result, 1 = load data, 2 = link/PC). A round-robin pointer picks the
// first requesting source at or after it; the winner is acknowledged in the
// same cycle and its address/data are registered onto the write port at the
// closing edge. A stall freezes the port and the pointer.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset
//   bus    wb_port_arbiter_if slave modport (requests, stall, ack, write port)
module wb_port_arbiter #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    wb_port_arbiter_if.slave  bus
);

    // Next source in rotation; an illegal pointer value of 3 wraps to 0.
    function automatic logic [1:0] wrap_inc(input logic [1:0] a);
        return (a >= 2'd2) ? 2'd0 : a + 2'd1;
    endfunction

    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        ptr_eff;
    logic              valid_q, valid_d;
    logic [1:0]        sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  data_q, data_d;

    logic              grant_any;
    logic [1:0]        grant_idx;
    logic [1:0]        cand;
    logic [2:0]        ack;

    assign ptr_eff = (ptr_q == 2'd3) ? 2'd0 : ptr_q;

    // Round-robin search: ptr, ptr+1, ptr+2 (mod 3), first requester wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = ptr_eff;
        cand      = ptr_eff;
        for (int i = 0; i < 3; i++) begin
            if (!grant_any && bus.req_i[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
            cand = wrap_inc(cand);
        end
        if (reset || bus.stall_i) begin
            grant_any = 1'b0;
        end
    end

    always_comb begin
        ack = 3'b000;
        if (grant_any) begin
            case (grant_idx)
                2'd0:    ack = 3'b001;
                2'd1:    ack = 3'b010;
                default: ack = 3'b100;
            endcase
        end
    end

    // Next-state for the write port. Stall holds everything; an idle,
    // unstalled cycle only drops valid.
    always_comb begin
        ptr_d   = ptr_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (!bus.stall_i) begin
            if (grant_any) begin
                valid_d = 1'b1;
                ptr_d   = wrap_inc(grant_idx);
                case (grant_idx)
                    2'd0: begin
                        sel_d  = 2'b00;
                        addr_d = bus.addr0_i;
                        data_d = bus.data0_i;
                    end
                    2'd1: begin
                        sel_d  = 2'b01;
                        addr_d = bus.addr1_i;
                        data_d = bus.data1_i;
                    end
                    default: begin
                        sel_d  = 2'b10;
                        addr_d = bus.addr2_i;
                        data_d = bus.data2_i;
                    end
                endcase
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= 2'd0;
            valid_q <= 1'b0;
            sel_q   <= 2'b00;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign bus.ack_o      = ack;
    assign bus.wb_valid_o = valid_q;
    assign bus.wb_sel_o   = sel_q;
    assign bus.wb_addr_o  = addr_q;
    assign bus.wb_data_o  = data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus a
// randomized run compared against a behavioural round-robin model.
module tb_wb_port_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    wb_port_arbiter_if #(.WIDTH(16), .ADDR_W(4)) bus ();

    wb_port_arbiter #(.WIDTH(16), .ADDR_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    int          m_ptr;
    logic        m_valid;
    logic [1:0]  m_sel;
    logic [3:0]  m_addr;
    logic [15:0] m_data;

    function automatic logic [2:0] model_ack();
        if (reset || bus.stall_i || bus.req_i == 3'b000) return 3'b000;
        for (int i = 0; i < 3; i++) begin
            int k;
            k = (m_ptr + i) % 3;
            if (bus.req_i[k]) return 3'(1 << k);
        end
        return 3'b000;
    endfunction

    task automatic model_update(input logic [2:0] a);
        if (reset) begin
            m_ptr = 0; m_valid = 0; m_sel = 0; m_addr = 0; m_data = 0;
        end else if (!bus.stall_i) begin
            if (a == 3'b000) begin
                m_valid = 0;
            end else begin
                int g;
                g = (a == 3'b001) ? 0 : (a == 3'b010) ? 1 : 2;
                m_valid = 1;
                m_sel   = 2'(g);
                m_addr  = (g == 0) ? bus.addr0_i : (g == 1) ? bus.addr1_i : bus.addr2_i;
                m_data  = (g == 0) ? bus.data0_i : (g == 1) ? bus.data1_i : bus.data2_i;
                m_ptr   = (g + 1) % 3;
            end
        end
    endtask

    // One clock: model follows the same inputs, outputs sampled 1 after the edge.
    task automatic tick();
        logic [2:0] a;
        a = model_ack();
        @(posedge clk);
        model_update(a);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; bus.stall_i = 0; bus.req_i = 3'b111;
        bus.addr0_i = 4'h3; bus.data0_i = 16'hBEEF;
        bus.addr1_i = 4'h1; bus.data1_i = 16'h1111;
        bus.addr2_i = 4'h2; bus.data2_i = 16'h2222;
        #1;
        checks++;
        if (bus.ack_o !== 3'b000) begin
            errors++; $display("FAIL reset_ack: got %b want 000", bus.ack_o);
        end
        tick(); tick();
        checks++;
        if (bus.wb_valid_o !== 1'b0 || bus.wb_sel_o !== 2'b00 || bus.wb_addr_o !== 4'h0
            || bus.wb_data_o !== 16'h0) begin
            errors++;
            $display("FAIL reset_regs: got v=%b s=%b a=%h d=%h want 0/00/0/0000",
                     bus.wb_valid_o, bus.wb_sel_o, bus.wb_addr_o, bus.wb_data_o);
        end
        reset = 0;
        #1;
        checks++;
        if (bus.ack_o !== 3'b001) begin
            errors++; $display("FAIL first_grant: got %b want 001", bus.ack_o);
        end
        tick();
        checks++;
        if (bus.wb_valid_o !== 1'b1 || bus.wb_sel_o !== 2'b00 || bus.wb_addr_o !== 4'h3
            || bus.wb_data_o !== 16'hBEEF) begin
            errors++;
            $display("FAIL first_write: got v=%b s=%b a=%h d=%h want 1/00/3/beef",
                     bus.wb_valid_o, bus.wb_sel_o, bus.wb_addr_o, bus.wb_data_o);
        end
    endtask

    task automatic test_single();
        bus.req_i = 3'b010; bus.addr1_i = 4'h5; bus.data1_i = 16'h1234;
        #1;
        checks++;
        if (bus.ack_o !== 3'b010) begin
            errors++; $display("FAIL single_ack: got %b want 010", bus.ack_o);
        end
        tick();
        checks++;
        if (bus.wb_valid_o !== 1'b1 || bus.wb_sel_o !== 2'b01 || bus.wb_addr_o !== 4'h5
            || bus.wb_data_o !== 16'h1234) begin
            errors++;
            $display("FAIL single_write: got v=%b s=%b a=%h d=%h want 1/01/5/1234",
                     bus.wb_valid_o, bus.wb_sel_o, bus.wb_addr_o, bus.wb_data_o);
        end
        bus.req_i = 3'b000;
        tick();
        checks++;
        if (bus.wb_valid_o !== 1'b0) begin
            errors++; $display("FAIL single_idle: got valid=%b want 0", bus.wb_valid_o);
        end
    endtask

    task automatic test_rotation();
        logic [2:0] exp_ack [6];
        exp_ack = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        reset = 1; bus.req_i = 3'b000;
        tick();
        reset = 0;
        bus.req_i = 3'b111;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (bus.ack_o !== exp_ack[i]) begin
                errors++; $display("FAIL rot_ack[%0d]: got %b want %b", i, bus.ack_o, exp_ack[i]);
            end
            tick();
            checks++;
            if (bus.wb_sel_o !== 2'(i % 3) || bus.wb_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL rot_sel[%0d]: got v=%b s=%b want 1/%0d",
                         i, bus.wb_valid_o, bus.wb_sel_o, i % 3);
            end
        end
        bus.req_i = 3'b000;
    endtask

    task automatic test_stall();
        bus.req_i = 3'b100; bus.addr2_i = 4'h7; bus.data2_i = 16'h00AA;
        #1;
        checks++;
        if (bus.ack_o !== 3'b100) begin
            errors++; $display("FAIL stall_pre_ack: got %b want 100", bus.ack_o);
        end
        tick();
        bus.stall_i = 1; bus.req_i = 3'b001; bus.data2_i = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.ack_o !== 3'b000) begin
                errors++; $display("FAIL stall_ack[%0d]: got %b want 000", i, bus.ack_o);
            end
            tick();
            checks++;
            if (bus.wb_valid_o !== 1'b1 || bus.wb_sel_o !== 2'b10 || bus.wb_data_o !== 16'h00AA) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b s=%b d=%h want 1/10/00aa",
                         i, bus.wb_valid_o, bus.wb_sel_o, bus.wb_data_o);
            end
        end
        bus.stall_i = 0;
        #1;
        checks++;
        if (bus.ack_o !== 3'b001) begin
            errors++; $display("FAIL stall_release_ack: got %b want 001", bus.ack_o);
        end
        tick();
        checks++;
        if (bus.wb_sel_o !== 2'b00 || bus.wb_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_sel: got v=%b s=%b want 1/00", bus.wb_valid_o, bus.wb_sel_o);
        end
        bus.req_i = 3'b000;
    endtask

    task automatic test_withdraw();
        reset = 1;
        tick();
        reset = 0;
        bus.stall_i = 1; bus.req_i = 3'b100;
        #1;
        checks++;
        if (bus.ack_o !== 3'b000) begin
            errors++; $display("FAIL withdraw_ack: got %b want 000", bus.ack_o);
        end
        tick();
        bus.stall_i = 0; bus.req_i = 3'b000;
        tick();
        checks++;
        if (bus.wb_valid_o !== 1'b0) begin
            errors++; $display("FAIL withdraw_nowrite: got valid=%b want 0", bus.wb_valid_o);
        end
        bus.req_i = 3'b011; bus.addr0_i = 4'hA; bus.data0_i = 16'hA0A0;
        #1;
        checks++;
        if (bus.ack_o !== 3'b001) begin
            errors++; $display("FAIL withdraw_first: got %b want 001", bus.ack_o);
        end
        tick();
        #1;
        checks++;
        if (bus.ack_o !== 3'b010 || bus.wb_addr_o !== 4'hA || bus.wb_data_o !== 16'hA0A0) begin
            errors++;
            $display("FAIL withdraw_second: got ack=%b a=%h d=%h want 010/a/a0a0",
                     bus.ack_o, bus.wb_addr_o, bus.wb_data_o);
        end
        tick();
        bus.req_i = 3'b000;
        tick();
    endtask

    task automatic test_reset_midstream();
        bus.req_i = 3'b110;
        tick();
        checks++;
        if (bus.wb_valid_o !== 1'b1) begin
            errors++; $display("FAIL mid_prevalid: got valid=%b want 1", bus.wb_valid_o);
        end
        reset = 1;
        #1;
        checks++;
        if (bus.ack_o !== 3'b000) begin
            errors++; $display("FAIL mid_reset_ack: got %b want 000", bus.ack_o);
        end
        tick();
        checks++;
        if (bus.wb_valid_o !== 1'b0 || bus.wb_sel_o !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_regs: got v=%b s=%b want 0/00", bus.wb_valid_o, bus.wb_sel_o);
        end
        reset = 0;
        #1;
        checks++;
        if (bus.ack_o !== 3'b010) begin
            errors++; $display("FAIL mid_after_ack: got %b want 010", bus.ack_o);
        end
        tick();
        checks++;
        if (bus.wb_sel_o !== 2'b01) begin
            errors++; $display("FAIL mid_after_sel: got %b want 01", bus.wb_sel_o);
        end
        bus.req_i = 3'b000;
    endtask

    task automatic test_random();
        logic [2:0] exp;
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 39) == 0);
            bus.stall_i = ($urandom_range(0, 3) == 0);
            bus.req_i   = 3'($urandom_range(0, 7));
            bus.addr0_i = 4'($urandom); bus.data0_i = 16'($urandom);
            bus.addr1_i = 4'($urandom); bus.data1_i = 16'($urandom);
            bus.addr2_i = 4'($urandom); bus.data2_i = 16'($urandom);
            #1;
            exp = model_ack();
            checks++;
            if (bus.ack_o !== exp) begin
                errors++; $display("FAIL rand_ack[%0d]: got %b want %b", i, bus.ack_o, exp);
            end
            tick();
            checks++;
            if (bus.wb_valid_o !== m_valid || bus.wb_sel_o !== m_sel
                || bus.wb_addr_o !== m_addr || bus.wb_data_o !== m_data) begin
                errors++;
                $display("FAIL rand_port[%0d]: got v=%b s=%b a=%h d=%h want %b/%b/%h/%h", i,
                         bus.wb_valid_o, bus.wb_sel_o, bus.wb_addr_o, bus.wb_data_o,
                         m_valid, m_sel, m_addr, m_data);
            end
        end
        reset = 0; bus.stall_i = 0; bus.req_i = 3'b000;
    endtask

    initial begin
        checks = 0; errors = 0;
        m_ptr = 0; m_valid = 0; m_sel = 0; m_addr = 0; m_data = 0;
        test_reset();
        test_single();
        test_rotation();
        test_stall();
        test_withdraw();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
